// File: rtl/latency_pipe_pkg.sv
// Shared definitions for the latency pipe receive side: counter width helper
// and error-flag bit positions used when packing status registers.
package latency_pipe_pkg;

  localparam int unsigned ERR_CREDIT_BIT   = 0;
  localparam int unsigned ERR_OVERFLOW_BIT = 1;
  localparam int unsigned ERR_NUM_BITS     = 2;

  function automatic int unsigned clog2p1(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through FIFO with arbitrary (non power-of-two) depth.
// A push into a full FIFO is accepted only when a pop frees a slot that cycle.
module sync_fifo_fwft
  import latency_pipe_pkg::*;
#(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        push,
  input  logic [WIDTH-1:0]            push_data,
  input  logic                        pop,
  output logic                        head_valid,
  output logic [WIDTH-1:0]            head_data,
  output logic [clog2p1(DEPTH)-1:0]   count,
  output logic                        full
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = clog2p1(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : PW'(p + 1'b1);
  endfunction

  assign full       = (count_q == CW'(DEPTH));
  assign head_valid = (count_q != '0);
  assign head_data  = mem_q[rd_ptr_q];
  assign count      = count_q;

  always_comb begin
    do_pop   = pop && head_valid;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = do_pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    if (do_push && !do_pop)      count_d = count_q + CW'(1);
    else if (do_pop && !do_push) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/latency_pipe_rx.sv
// Receive end of a fixed-latency pipe: buffers arriving entries, returns
// credits to the issuer on each pop and flags credit misuse and overflow.
module latency_pipe_rx
  import latency_pipe_pkg::*;
#(
  parameter int unsigned NUM_DELAY  = 5,
  parameter int unsigned PIPE_WIDTH = 1,
  parameter int unsigned DEPTH      = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        issue,
  output logic                        credit_avail,
  output logic [clog2p1(DEPTH)-1:0]   credit_count,
  input  logic                        pipe_valid,
  input  logic [PIPE_WIDTH-1:0]       pipe_data,
  output logic                        out_valid,
  output logic [PIPE_WIDTH-1:0]       out_data,
  input  logic                        out_ready,
  output logic [clog2p1(DEPTH)-1:0]   occupancy,
  output logic                        err_credit,
  output logic                        err_overflow
);

  localparam int unsigned CW = clog2p1(DEPTH);

  logic [CW-1:0]           credit_q, credit_d;
  logic [ERR_NUM_BITS-1:0] err_q, err_d;
  logic                    head_valid, fifo_full, pop, take;
  logic [PIPE_WIDTH-1:0]   head_data;

  sync_fifo_fwft #(
    .WIDTH (PIPE_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (pipe_valid),
    .push_data  (pipe_data),
    .pop        (pop),
    .head_valid (head_valid),
    .head_data  (head_data),
    .count      (occupancy),
    .full       (fifo_full)
  );

  assign pop = head_valid && out_ready;

  always_comb begin
    take     = issue && (credit_q != '0);
    credit_d = credit_q;
    if (take && !pop)      credit_d = credit_q - CW'(1);
    else if (pop && !take) credit_d = credit_q + CW'(1);
    err_d = err_q;
    if (issue && (credit_q == '0))           err_d[ERR_CREDIT_BIT]   = 1'b1;
    if (pipe_valid && fifo_full && !pop)     err_d[ERR_OVERFLOW_BIT] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      credit_q <= CW'(DEPTH);
      err_q    <= '0;
    end else begin
      credit_q <= credit_d;
      err_q    <= err_d;
    end
  end

  assign credit_count = credit_q;
  assign credit_avail = (credit_q != '0);
  assign out_valid    = head_valid;
  assign out_data     = head_valid ? head_data : '0;
  assign err_credit   = err_q[ERR_CREDIT_BIT];
  assign err_overflow = err_q[ERR_OVERFLOW_BIT];

endmodule

// File: tb/tb_latency_pipe_rx.sv
// Directed bench for latency_pipe_rx: inputs change and outputs are checked
// on the falling edge, so each check sees the state after the preceding rise.
module tb_latency_pipe_rx;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned W     = 4;

  logic         clk, rst, issue, pipe_valid, out_ready;
  logic [W-1:0] pipe_data, out_data;
  logic         credit_avail, out_valid, err_credit, err_overflow;
  logic [3:0]   credit_count, occupancy;

  int unsigned total  = 0;
  int unsigned passed = 0;
  logic [W-1:0] drain_exp [8];

  latency_pipe_rx #(
    .NUM_DELAY  (5),
    .PIPE_WIDTH (W),
    .DEPTH      (DEPTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .issue        (issue),
    .credit_avail (credit_avail),
    .credit_count (credit_count),
    .pipe_valid   (pipe_valid),
    .pipe_data    (pipe_data),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_ready    (out_ready),
    .occupancy    (occupancy),
    .err_credit   (err_credit),
    .err_overflow (err_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Issue 8 back-to-back; each entry arrives 5 cycles later with data 1..8.
  task automatic fill();
    for (int c = 0; c < 13; c++) begin
      issue      = (c < 8);
      pipe_valid = (c >= 5);
      pipe_data  = (c >= 5) ? W'(c - 4) : '0;
      @(negedge clk);
      chk("fill_credit", credit_count, (c < 8) ? 32'(7 - c) : 32'd0);
      chk("fill_avail",  credit_avail, (c < 7) ? 32'd1 : 32'd0);
      chk("fill_occ",    occupancy,    (c >= 5) ? 32'(c - 4) : 32'd0);
      chk("fill_errs",   {err_credit, err_overflow}, 32'd0);
    end
    issue      = 1'b0;
    pipe_valid = 1'b0;
    pipe_data  = '0;
  endtask

  initial begin
    rst = 1'b1; issue = 1'b0; pipe_valid = 1'b0; pipe_data = '0; out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_credit",   credit_count, 32'd8);
    chk("rst_avail",    credit_avail, 32'd1);
    chk("rst_valid",    out_valid,    32'd0);
    chk("rst_data",     out_data,     32'd0);
    chk("rst_occ",      occupancy,    32'd0);
    chk("rst_errs",     {err_credit, err_overflow}, 32'd0);

    fill();
    chk("full_valid", out_valid, 32'd1);
    chk("full_head",  out_data,  32'd1);

    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("drain_data",   out_data,     32'(i + 1));
      chk("drain_credit", credit_count, 32'(i));
      @(negedge clk);
    end
    out_ready = 1'b0;
    chk("drained_credit", credit_count, 32'd8);
    chk("drained_occ",    occupancy,    32'd0);
    chk("drained_valid",  out_valid,    32'd0);
    chk("drained_data",   out_data,     32'd0);

    fill();
    pipe_valid = 1'b1; pipe_data = 4'hA; out_ready = 1'b1;
    @(negedge clk);
    pipe_valid = 1'b0; pipe_data = '0; out_ready = 1'b0;
    chk("pp_occ",    occupancy,    32'd8);
    chk("pp_credit", credit_count, 32'd1);
    chk("pp_ovf",    err_overflow, 32'd0);
    chk("pp_head",   out_data,     32'd2);

    issue = 1'b1;
    @(negedge clk);
    chk("iss_credit", credit_count, 32'd0);
    chk("iss_err",    err_credit,   32'd0);
    @(negedge clk);
    issue = 1'b0;
    chk("nocred_credit", credit_count, 32'd0);
    chk("nocred_err",    err_credit,   32'd1);
    chk("nocred_avail",  credit_avail, 32'd0);

    pipe_valid = 1'b1; pipe_data = 4'hF;
    @(negedge clk);
    pipe_valid = 1'b0; pipe_data = '0;
    chk("ovf_err", err_overflow, 32'd1);
    chk("ovf_occ", occupancy,    32'd8);

    drain_exp = '{4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'hA};
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("drain2_data", out_data, 32'(drain_exp[i]));
      @(negedge clk);
    end
    out_ready = 1'b0;
    chk("drain2_valid",  out_valid,    32'd0);
    chk("drain2_credit", credit_count, 32'd8);
    chk("sticky_errs",   {err_credit, err_overflow}, 32'd3);

    for (int c = 0; c < 6; c++) begin
      issue      = 1'b1;
      pipe_valid = (c >= 3);
      pipe_data  = W'(c);
      @(negedge clk);
    end
    issue = 1'b0; pipe_valid = 1'b0; pipe_data = '0;
    chk("pre_rst_credit", credit_count, 32'd2);
    chk("pre_rst_occ",    occupancy,    32'd3);
    chk("pre_rst_head",   out_data,     32'd3);

    rst = 1'b1; issue = 1'b1; pipe_valid = 1'b1; pipe_data = 4'h5; out_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0; issue = 1'b0; pipe_valid = 1'b0; pipe_data = '0; out_ready = 1'b0;
    chk("mid_rst_occ",    occupancy,    32'd0);
    chk("mid_rst_credit", credit_count, 32'd8);
    chk("mid_rst_valid",  out_valid,    32'd0);
    chk("mid_rst_data",   out_data,     32'd0);
    chk("mid_rst_errs",   {err_credit, err_overflow}, 32'd0);
    @(negedge clk);
    chk("post_rst_occ", occupancy, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
